// File: rtl/mem_ctrl_seq.sv
// ---------------------------------------------------------------------------
// mem_ctrl_seq
//
// Sequenced KS-10 backplane memory interface. Decodes bus cycles (read,
// write-test, write, read-modify-write, IO), drives a synchronous SRAM with
// a configurable read latency and write-pulse length, returns data with a
// registered one-cycle ACK, and hosts the Memory Status Register (MSR) with
// nonexistent-memory (NXM) detection.
//
// Bus words use KS-10 bit numbering: bit 0 is the MSB, bit 35 the LSB.
//
// Optional build macro:
//   MEM_ERA_EN  - adds the Error Address Register. The address of the first
//                 NXM reference (taken while NXM was clear) is returned in
//                 MSR bits 14:35. Without it those MSR bits read 0.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   busREQI    bus request, held high until the ACK is seen
//   busADDRI   bus address and cycle flags
//   busDATAI   bus write data
//   busACKO    one-cycle acknowledge
//   busDATAO   read data, valid while busACKO=1, otherwise 0
//   ssramCE    SRAM chip enable
//   ssramOE_N  SRAM output enable (active low)
//   ssramWE_N  SRAM write enable (active low)
//   ssramADDR  SRAM word address
//   ssramDOUT  SRAM write data
//   ssramDOE   write-data drive enable for the top-level tristate
//   ssramDIN   SRAM read data
// ---------------------------------------------------------------------------
module mem_ctrl_seq #(
    parameter int          ADDR_WIDTH = 20,
    parameter int          MEM_WORDS  = 1 << 20,
    parameter int          RD_LAT     = 2,
    parameter int          WR_CYC     = 1,
    parameter logic [3:0]  MEM_DEV    = 4'd0,
    parameter logic [17:0] MSR_ADDR   = 18'o100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  busREQI,
    input  logic [0:35]           busADDRI,
    input  logic [0:35]           busDATAI,
    output logic                  busACKO,
    output logic [0:35]           busDATAO,
    output logic                  ssramCE,
    output logic                  ssramOE_N,
    output logic                  ssramWE_N,
    output logic [ADDR_WIDTH-1:0] ssramADDR,
    output logic [0:35]           ssramDOUT,
    output logic                  ssramDOE,
    input  logic [0:35]           ssramDIN
);

    // Bus flag positions (KS-10 numbering).
    localparam int BIT_READ   = 3;
    localparam int BIT_WRTEST = 4;
    localparam int BIT_WRITE  = 5;
    localparam int BIT_IO     = 7;
    localparam int BIT_PHYS   = 8;
    localparam int BIT_ACREF  = 12;

    localparam logic [2:0]          RD_INIT   = 3'(RD_LAT - 1);
    localparam logic [2:0]          WR_INIT   = 3'(WR_CYC - 1);
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        RDWAIT,
        WRPULSE,
        ACK,
        HOLD
    } stateE;

    stateE state;
    stateE stateNxt;

    // Control registers and their next values.
    logic [2:0]            cnt, cntNxt;
    logic                  rmwR, rmwNxt;
    logic                  wrHold, wrHoldNxt;
    logic                  ceNxt, oeNxt, weNxt, doeNxt;
    logic [ADDR_WIDTH-1:0] addrNxt;
    logic                  ackNxt;
    logic [0:35]           busDataNxt;
    logic                  msrPE, msrEE, msrPF, msrNXM;
    logic                  peNxt, eeNxt, pfNxt, nxmNxt;

    // Data registers (no reset needed).
    logic [0:35]           dataR, dataNxt;
    logic [0:35]           doutNxt;

`ifdef MEM_ERA_EN
    logic [0:21]           eraR, eraNxt;
`endif

    // Request decode.
    logic                  isRead, isWrTest, isWrite, isIO, isPhys, isAcref;
    logic [3:0]            ioDev;
    logic [17:0]           ioAddr;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic                  msrHit;
    logic                  memNxm;
    logic [0:35]           msrImage;
    logic                  unusedBits;

    assign isRead   = busADDRI[BIT_READ];
    assign isWrTest = busADDRI[BIT_WRTEST];
    assign isWrite  = busADDRI[BIT_WRITE];
    assign isIO     = busADDRI[BIT_IO];
    assign isPhys   = busADDRI[BIT_PHYS];
    assign isAcref  = busADDRI[BIT_ACREF];
    assign ioDev    = busADDRI[14:17];
    assign ioAddr   = busADDRI[18:35];
    assign memAddr  = busADDRI[36-ADDR_WIDTH:35];

    assign msrHit = isIO && isPhys && (ioDev == MEM_DEV) && (ioAddr == MSR_ADDR);
    assign memNxm = ({1'b0, memAddr} >= MEM_LIMIT);

    assign unusedBits = ^{busADDRI[0:2], busADDRI[6], busADDRI[9:11], busADDRI[13]};

    // MSR read image; NXM is reported in the UE position (bit 1).
    always_comb begin
        msrImage     = '0;
        msrImage[1]  = msrNXM;
        msrImage[3]  = msrPE;
        msrImage[4]  = msrEE;
        msrImage[12] = msrPF;
`ifdef MEM_ERA_EN
        msrImage[14:35] = eraR;
`endif
    end

    // ---- state register -----------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rmwR      <= 1'b0;
            wrHold    <= 1'b0;
            ssramCE   <= 1'b0;
            ssramOE_N <= 1'b1;
            ssramWE_N <= 1'b1;
            ssramDOE  <= 1'b0;
            ssramADDR <= '0;
            busACKO   <= 1'b0;
            busDATAO  <= '0;
            msrPE     <= 1'b0;
            msrEE     <= 1'b1;
            msrPF     <= 1'b1;
            msrNXM    <= 1'b0;
`ifdef MEM_ERA_EN
            eraR      <= '0;
`endif
        end else begin
            state     <= stateNxt;
            cnt       <= cntNxt;
            rmwR      <= rmwNxt;
            wrHold    <= wrHoldNxt;
            ssramCE   <= ceNxt;
            ssramOE_N <= oeNxt;
            ssramWE_N <= weNxt;
            ssramDOE  <= doeNxt;
            ssramADDR <= addrNxt;
            busACKO   <= ackNxt;
            busDATAO  <= busDataNxt;
            msrPE     <= peNxt;
            msrEE     <= eeNxt;
            msrPF     <= pfNxt;
            msrNXM    <= nxmNxt;
`ifdef MEM_ERA_EN
            eraR      <= eraNxt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        dataR     <= dataNxt;
        ssramDOUT <= doutNxt;
    end

    // ---- next-state logic ---------------------------------------------
    always_comb begin
        stateNxt = state;
        case (state)
            IDLE: begin
                if (busREQI) begin
                    if (isIO) begin
                        // IO cycles not addressed to the MSR are left for other devices.
                        if (msrHit && (isRead || isWrite)) stateNxt = ACK;
                    end else if (memNxm) begin
                        // No ACK: the CPU detects NXM by timing out.
                        stateNxt = HOLD;
                    end else if (isRead || isWrTest) begin
                        stateNxt = RDWAIT;
                    end else if (isWrite) begin
                        stateNxt = isAcref ? ACK : WRPULSE;
                    end
                end
            end
            RDWAIT: begin
                if (cnt == 3'd0) stateNxt = rmwR ? WRPULSE : ACK;
            end
            WRPULSE: begin
                if (wrHold) stateNxt = ACK;
            end
            ACK: begin
                stateNxt = HOLD;
            end
            HOLD: begin
                if (!busREQI) stateNxt = IDLE;
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase
    end

    // ---- output / datapath logic --------------------------------------
    always_comb begin
        cntNxt     = cnt;
        rmwNxt     = rmwR;
        wrHoldNxt  = wrHold;
        ceNxt      = ssramCE;
        oeNxt      = ssramOE_N;
        weNxt      = ssramWE_N;
        doeNxt     = ssramDOE;
        addrNxt    = ssramADDR;
        peNxt      = msrPE;
        eeNxt      = msrEE;
        pfNxt      = msrPF;
        nxmNxt     = msrNXM;
        dataNxt    = dataR;
        doutNxt    = ssramDOUT;
`ifdef MEM_ERA_EN
        eraNxt     = eraR;
`endif
        // The ACK pulse and its data are registered from the ACK state, so
        // busDATAO is non-zero only while busACKO is high.
        ackNxt     = (state == ACK);
        busDataNxt = (state == ACK) ? dataR : '0;

        case (state)
            IDLE: begin
                if (busREQI) begin
                    if (isIO) begin
                        if (msrHit && isRead) begin
                            dataNxt = msrImage;
                        end else if (msrHit && isWrite) begin
                            // Bit 4 reads as EE but is written as NXM-clear.
                            peNxt   = busDATAI[3];
                            pfNxt   = busDATAI[12] & msrPF;
                            eeNxt   = !busDATAI[35];
                            nxmNxt  = msrNXM & busDATAI[4];
                            dataNxt = '0;
                        end
                    end else if (memNxm) begin
                        nxmNxt = 1'b1;
`ifdef MEM_ERA_EN
                        // Only the first failing address after NXM was clear is kept.
                        if (!msrNXM) eraNxt = busADDRI[14:35];
`endif
                    end else if (isRead || isWrTest) begin
                        ceNxt   = 1'b1;
                        oeNxt   = 1'b0;
                        addrNxt = memAddr;
                        cntNxt  = RD_INIT;
                        rmwNxt  = isWrite;
                        doutNxt = busDATAI;
                    end else if (isWrite) begin
                        dataNxt = '0;
                        if (!isAcref) begin
                            ceNxt     = 1'b1;
                            doeNxt    = 1'b1;
                            weNxt     = 1'b0;
                            addrNxt   = memAddr;
                            doutNxt   = busDATAI;
                            cntNxt    = WR_INIT;
                            wrHoldNxt = 1'b0;
                        end
                    end
                end
            end
            RDWAIT: begin
                if (cnt == 3'd0) begin
                    dataNxt = ssramDIN;
                    oeNxt   = 1'b1;
                    if (rmwR) begin
                        // Write phase of RMW reuses the address and data latched at issue.
                        weNxt     = 1'b0;
                        doeNxt    = 1'b1;
                        cntNxt    = WR_INIT;
                        wrHoldNxt = 1'b0;
                    end else begin
                        ceNxt = 1'b0;
                    end
                end else begin
                    cntNxt = cnt - 3'd1;
                end
            end
            WRPULSE: begin
                if (wrHold) begin
                    // Data and chip enable were held one cycle past WE_N rising.
                    ceNxt  = 1'b0;
                    doeNxt = 1'b0;
                end else if (cnt == 3'd0) begin
                    weNxt     = 1'b1;
                    wrHoldNxt = 1'b1;
                end else begin
                    cntNxt = cnt - 3'd1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
